// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: CPU and debug requesters plus the MMU side.
// slave: arbiter view; master: requesters/MMU view (fence_busy, m_do in).
interface dm_port_arbiter_if;
  logic        fence_busy;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_signed;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [3:0]  dbg_be;
  logic        dbg_burst;
  logic        dbg_last;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_di;
  logic [3:0]  m_be;
  logic        m_signed;
  logic [31:0] m_do;

  modport slave (
    input  fence_busy,
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, cpu_be, cpu_signed,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr,
    input  dbg_wdata, dbg_be,
    input  dbg_burst, dbg_last,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output m_addr, m_we, m_di, m_be, m_signed,
    input  m_do
  );

  modport master (
    output fence_busy,
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, cpu_be, cpu_signed,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr,
    output dbg_wdata, dbg_be,
    output dbg_burst, dbg_last,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  m_addr, m_we, m_di, m_be, m_signed,
    output m_do
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Arbitrates the MMU data port between CPU and debug/loader.
// Ports: clk, resetb (sync, active-low), bus (dm_port_arbiter_if.slave),
// conflict_cnt[15:0] only when ARB_PERF_CNT_EN is defined.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input logic               clk,
  input logic               resetb,
  dm_port_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] DBG_BURST = 1'b1;

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(STARVE_LIMIT);

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             cpu_rd_q;
  logic             cpu_rd_d;
  logic             dbg_rd_q;
  logic             dbg_rd_d;
  logic             cpu_gnt;
  logic             dbg_gnt;
  logic             starved;

  assign starved = (starve_q == LIMIT);

  // Grants are masked by reset so no write can
  // leak out while resetb is low.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (resetb && !bus.fence_busy) begin
      unique case (state_q)
        DBG_BURST: begin
          dbg_gnt = bus.dbg_req;
        end
        IDLE: begin
          dbg_gnt = bus.dbg_req &
                    (~bus.cpu_req | starved);
          cpu_gnt = bus.cpu_req & ~dbg_gnt;
        end
        default: begin
          cpu_gnt = 1'b0;
          dbg_gnt = 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_gnt = cpu_gnt;
  assign bus.dbg_gnt = dbg_gnt;

  always_comb begin
    bus.m_addr   = '0;
    bus.m_we     = 1'b0;
    bus.m_di     = '0;
    bus.m_be     = '0;
    bus.m_signed = 1'b0;
    unique case (1'b1)
      cpu_gnt: begin
        bus.m_addr   = bus.cpu_addr;
        bus.m_we     = bus.cpu_we;
        bus.m_di     = bus.cpu_wdata;
        bus.m_be     = bus.cpu_be;
        bus.m_signed = bus.cpu_signed;
      end
      dbg_gnt: begin
        bus.m_addr   = bus.dbg_addr;
        bus.m_we     = bus.dbg_we;
        bus.m_di     = bus.dbg_wdata;
        bus.m_be     = bus.dbg_be;
        bus.m_signed = 1'b0;
      end
      default: begin
        bus.m_addr   = '0;
      end
    endcase
  end

  // Burst ownership is frozen while a fence
  // copy holds the port.
  always_comb begin
    state_d = state_q;
    if (!bus.fence_busy) begin
      unique case (state_q)
        IDLE: begin
          if (dbg_gnt && bus.dbg_burst &&
              !bus.dbg_last)
            state_d = DBG_BURST;
        end
        DBG_BURST: begin
          if ((dbg_gnt && bus.dbg_last) ||
              !bus.dbg_req)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Only cycles actually lost to the CPU count.
  always_comb begin
    starve_d = starve_q;
    if (dbg_gnt)
      starve_d = '0;
    else if (bus.dbg_req && cpu_gnt && !starved)
      starve_d = starve_q + CNT_W'(1);
  end

  assign cpu_rd_d = cpu_gnt & ~bus.cpu_we;
  assign dbg_rd_d = dbg_gnt & ~bus.dbg_we;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q  <= IDLE;
      starve_q <= '0;
      cpu_rd_q <= 1'b0;
      dbg_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cpu_rd_q <= cpu_rd_d;
      dbg_rd_q <= dbg_rd_d;
    end
  end

  assign bus.cpu_rvalid = cpu_rd_q;
  assign bus.dbg_rvalid = dbg_rd_q;
  assign bus.cpu_rdata  = cpu_rd_q ? bus.m_do : '0;
  assign bus.dbg_rdata  = dbg_rd_q ? bus.m_do : '0;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflict_q;
  logic [15:0] conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (bus.cpu_req && bus.dbg_req &&
        !bus.fence_busy &&
        conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetb)
      conflict_q <= '0;
    else
      conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
Shares the single data-memory port of the MMU (RAM data bank plus I/O window) between two requesters: the CPU load/store stage and the debug/program-loader port. It grants one access per cycle and routes the one-cycle-latency read data back to the requester that issued the read. It holds off both requesters while a FENCE.I copy is in progress. Debug bursts take exclusive ownership of the port, and a starvation counter prevents the CPU from locking debug out indefinitely.

Parameters:
STARVE_LIMIT, 8, number of consecutive cycles debug may lose to the CPU before debug gets forced priority (minimum 1)
CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  in  1  clock
resetb  in  1  reset, synchronous, active-low
fence_busy  in  1  MMU FENCE.I copy active; blocks all grants
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write enable
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_be  in  4  CPU byte enables
cpu_signed  in  1  CPU sign-extend for loads
cpu_gnt  out  1  CPU request accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  32  CPU read data
dbg_req  in  1  debug access request
dbg_we  in  1  debug write enable
dbg_addr  in  32  debug byte address
dbg_wdata  in  32  debug write data
dbg_be  in  4  debug byte enables
dbg_burst  in  1  beat belongs to a burst; keep ownership after it
dbg_last  in  1  final beat of a burst
dbg_gnt  out  1  debug request accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  32  debug read data
m_addr  out  32  to MMU dm_addr
m_we  out  1  to MMU dm_we
m_di  out  32  to MMU dm_di
m_be  out  4  to MMU dm_be
m_signed  out  1  to MMU is_signed; 0 for debug accesses
m_do  in  32  from MMU dm_do; valid the cycle after the access

Behaviour:
- Clock and reset: all state is updated on posedge clk. resetb is synchronous and active-low.
- Reset values: state=IDLE, starve_cnt=0, cpu_rvalid=0, dbg_rvalid=0. cpu_rdata and dbg_rdata are 0. While resetb=0, cpu_gnt=0, dbg_gnt=0, m_we=0, m_be=0.
- States:
  - IDLE: no burst in progress.
  - DBG_BURST: debug owns the port.
- Grant logic (combinational from state, requests, fence_busy and starve_cnt):
  - fence_busy=1: no grant at all.
  - DBG_BURST: dbg_gnt=dbg_req; cpu_gnt=0.
  - IDLE, both requesting: CPU wins unless starve_cnt==STARVE_LIMIT, in which case debug wins.
  - IDLE, single requester: that requester is granted.
- Memory port muxing: m_* carry the granted requester's fields. With no grant, m_we=0, m_be=0, and m_addr, m_di, m_signed=0. A write is issued only on a granted cycle.
- Transitions:
  - IDLE->DBG_BURST when dbg_gnt & dbg_burst & ~dbg_last.
  - DBG_BURST->IDLE when dbg_gnt & dbg_last, or when dbg_req=0 (abandoned burst).
  - fence_busy does not change state. Burst ownership is kept across a fence.
- Starvation counter:
  - Increments by 1, saturating at STARVE_LIMIT, when dbg_req & ~dbg_gnt & cpu_gnt.
  - Clears to 0 on dbg_gnt.
  - Otherwise holds. Cycles stalled by fence_busy do not count.
- Read return, latency 1:
  - Registered owner tag: cpu_rd_p = cpu_gnt & ~cpu_we, dbg_rd_p = dbg_gnt & ~dbg_we.
  - cpu_rvalid = cpu_rd_p. cpu_rdata = m_do when cpu_rd_p, else 0. Same rule for the debug port.
  - Writes produce no rvalid.
  - At most one rvalid is high in any cycle.
- Back-to-back: one grant per cycle is allowed, so full throughput is one access per cycle. Read data for access N appears in the same cycle as the grant for access N+1.
- Requester obligation: a requester holds its request fields stable until it is granted.
- Reset mid-burst: returns to IDLE. The pending rvalid is dropped (0 the cycle after reset).

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined: adds output conflict_cnt [15:0]. It increments, saturating at 0xFFFF, each cycle where cpu_req & dbg_req & ~fence_busy, and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- CPU-only read at addr 0x00000010: cpu_gnt=1 in cycle 0; cycle 1 shows cpu_rvalid=1 and cpu_rdata=m_do; dbg_rvalid stays 0.
- Continuous cpu_req with dbg_req both high, STARVE_LIMIT=8: CPU granted 8 cycles, dbg_gnt=1 in the 9th, then starve_cnt=0 and the CPU wins again.
- Debug burst of 4 writes (dbg_burst=1, dbg_last on beat 4) with cpu_req high throughout: cpu_gnt=0 for all 4 beats; CPU is granted the cycle after beat 4; m_we=1 only on granted beats.
- fence_busy=1 for 5 cycles with both requesters active: no grants, m_we=0, starve_cnt unchanged; arbitration resumes on the cycle fence_busy falls.
- Alternating CPU read then debug read back-to-back: each rvalid asserts on the correct port only, one cycle after its grant.
- resetb=0 asserted during DBG_BURST with a debug read outstanding: next cycle dbg_rvalid=0 and state=IDLE; after release, a CPU request is granted immediately.
